// File: rtl/fifo_serializer_pkg.sv
// fifo_serializer_pkg: shared word width and FSM state encodings for the FIFO serializer.
package fifo_serializer_pkg;
    localparam int DATA_W = 16;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        CAP   = 2'd2,
        SHIFT = 2'd3
    } state_t;
endpackage

// File: rtl/bit_tick_gen.sv
// bit_tick_gen: bit-period divider; counts 0..BIT_DIV-1 and ticks on the last count of each period.
module bit_tick_gen #(
    parameter int BIT_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    output logic o_tick
);
    logic [7:0] r_cnt;
    logic       w_wrap;
    assign w_wrap = r_cnt == 8'(BIT_DIV - 1);
    assign o_tick = w_wrap;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_cnt <= '0;
        else        r_cnt <= (i_clr || w_wrap) ? '0 : r_cnt + 8'd1;
    end
endmodule

// File: rtl/fifo_serializer.sv
// fifo_serializer: pops words from an upstream synch_fifo and shifts them out MSB first,
// holding each bit for BIT_DIV cycles.
module fifo_serializer
    import fifo_serializer_pkg::*;
#(
    parameter int DATA_W  = fifo_serializer_pkg::DATA_W,
    parameter int BIT_DIV = 2,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_read_data,
    output logic              fifo_rd_en,
    output logic              ser_data,
    output logic              ser_valid,
    output logic              ser_first,
    output logic              busy,
    output logic [CNT_W-1:0]  word_cnt
);
    localparam int BW = $clog2(DATA_W + 1);
    state_t            r_state, w_next;
    logic [DATA_W-1:0] r_shift;
    logic [BW-1:0]     r_bit;
    logic              r_arm;
    logic              w_tick, w_last, w_go;
    assign w_go   = en && !fifo_empty;
    assign w_last = (r_state == SHIFT) && w_tick && (r_bit == BW'(DATA_W - 1));
    bit_tick_gen #(.BIT_DIV(BIT_DIV)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (r_state == CAP),
        .o_tick (w_tick)
    );
    // r_arm holds off the first pop until one full edge has passed after reset release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_arm   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_arm   <= 1'b1;
        end
    end
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = (r_arm && w_go) ? REQ : IDLE;
            REQ:     w_next = CAP;
            CAP:     w_next = SHIFT;
            SHIFT:   w_next = w_last ? (w_go ? REQ : IDLE) : SHIFT;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift  <= '0;
            r_bit    <= '0;
            word_cnt <= '0;
        end else begin
            if (r_state == CAP) begin
                r_shift <= fifo_read_data;
                r_bit   <= '0;
            end else if (r_state == SHIFT && w_tick) begin
                r_shift <= {r_shift[DATA_W-2:0], 1'b0};
                r_bit   <= r_bit + BW'(1);
            end
            if (w_last) word_cnt <= word_cnt + CNT_W'(1);
        end
    end
    assign fifo_rd_en = r_state == REQ;
    assign busy       = r_state != IDLE;
    assign ser_valid  = r_state == SHIFT;
    assign ser_data   = ser_valid && r_shift[DATA_W-1];
    assign ser_first  = ser_valid && (r_bit == '0);
endmodule

// File: tb/tb_fifo_serializer.sv
// tb_fifo_serializer: FIFO model upstream, bit-stream reference model on the serial side,
// directed vectors plus randomized traffic.
module tb_fifo_serializer;
    localparam int DW = 16;
    localparam int BD = 2;
    localparam int N  = DW * BD;
    logic clk = 1'b0, reset = 1'b1, en = 1'b0, fifo_empty = 1'b1;
    logic [DW-1:0] fifo_read_data = '0;
    logic fifo_rd_en, ser_data, ser_valid, ser_first, busy;
    logic rd2, sd2, sv2, sf2, b2;
    logic [7:0] word_cnt;
    logic [1:0] wc2;
    int checks = 0, errors = 0, pops = 0, run = 0, ones = 0, gap = 0;
    int last_len = 0, last_ones = 0, last_gap = 0, exp_cnt = 0, sent = 0, p0 = 0;
    logic [DW-1:0] fq[$], popped[$], cur = '0, pw;
    typedef struct { logic [DW-1:0] w; int ones; int cnt; } vec_t;
    vec_t tbl[5];
    int wrap_exp[5] = '{1, 2, 3, 0, 1};

    always #5 clk = ~clk;

    fifo_serializer #(.DATA_W(DW), .BIT_DIV(BD), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .en(en), .fifo_empty(fifo_empty), .fifo_read_data(fifo_read_data),
        .fifo_rd_en(fifo_rd_en), .ser_data(ser_data), .ser_valid(ser_valid), .ser_first(ser_first),
        .busy(busy), .word_cnt(word_cnt));
    fifo_serializer #(.DATA_W(DW), .BIT_DIV(BD), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .en(en), .fifo_empty(fifo_empty), .fifo_read_data(fifo_read_data),
        .fifo_rd_en(rd2), .ser_data(sd2), .ser_valid(sv2), .ser_first(sf2),
        .busy(b2), .word_cnt(wc2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] w);
        fq.push_back(w);
        fifo_empty = 1'b0;
        sent++;
    endtask

    task automatic wait_idle(input string name);
        int k;
        step(1);
        for (k = 0; k < 3000; k++) begin
            if (!busy && (!en || fq.size() == 0)) break;
            step(1);
        end
        if (k == 3000) chk({name, "_timeout"}, 1, 0);
    endtask

    task automatic wait_run(input int r);
        int k;
        for (k = 0; k < 500; k++) begin
            if (run == r) break;
            step(1);
        end
        if (k == 500) chk("wait_run_timeout", 1, 0);
    endtask

    // upstream synch_fifo: data appears the cycle after the pop request
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (fq.size() == 0) chk("rd_en_while_empty", 1, 0);
            else begin
                pw = fq.pop_front();
                fifo_read_data <= pw;
                popped.push_back(pw);
                pops++;
            end
        end
        fifo_empty <= fq.size() == 0;
    end

    // serial-side reference: every valid run must be whole words, MSB first, each bit BD cycles
    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_valid", ser_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_cnt", word_cnt, 0);
            chk("rst_rd_en", fifo_rd_en, 0);
            run = 0; ones = 0; gap = 0; exp_cnt = 0;
            popped.delete();
        end else begin
            chk("word_cnt", word_cnt, exp_cnt % 256);
            chk("word_cnt_w2", wc2, exp_cnt % 4);
            if (ser_valid) begin
                if (run == 0) last_gap = gap;
                if (run % N == 0) begin
                    if (popped.size() == 0) chk("word_avail", 0, 1);
                    else cur = popped.pop_front();
                end
                chk("ser_data", ser_data, cur[DW-1-(run%N)/BD]);
                chk("ser_first", ser_first, ((run % N) < BD) ? 1 : 0);
                chk("busy_shift", busy, 1);
                ones += ser_data ? 1 : 0;
                run++;
                if (run % N == 0) exp_cnt++;
                gap = 0;
            end else begin
                chk("idle_outs", {ser_data, ser_first}, 0);
                if (run != 0) begin
                    chk("burst_whole", run % N, 0);
                    last_len = run; last_ones = ones; run = 0; ones = 0;
                end
                gap++;
            end
        end
    end

    initial begin
        tbl[0] = '{16'h8001, 4, 2};
        tbl[1] = '{16'h7FFE, 28, 3};
        tbl[2] = '{16'h0000, 0, 4};
        tbl[3] = '{16'hFFFF, 32, 5};
        tbl[4] = '{16'h1234, 10, 6};
        #1 reset = 1'b0;
        en = 1'b1;
        step(3);
        chk("reset_busy", busy, 0);
        push(16'hA5C3);
        step(2);
        chk("no_pop_in_reset", pops, 0);
        reset = 1'b1;
        step(1);
        chk("arm_delay", fifo_rd_en, 0);
        step(1);
        chk("first_req", fifo_rd_en, 1);
        step(1);
        chk("cap_rd_en", fifo_rd_en, 0);
        chk("cap_busy", busy, 1);
        step(1);
        chk("shift_start", {ser_valid, ser_first, ser_data}, 3'b111);
        wait_idle("single");
        chk("single_len", last_len, N);
        chk("single_ones", last_ones, 16);
        chk("single_cnt", word_cnt, 1);
        chk("single_pops", pops, 1);

        for (int i = 0; i < 5; i++) begin
            push(tbl[i].w);
            step(1);
            chk("lat_req", fifo_rd_en, 1);
            step(1);
            chk("lat_cap", {fifo_rd_en, ser_valid}, 0);
            step(1);
            chk("lat_shift", {ser_valid, ser_first}, 2'b11);
            wait_idle("vec");
            chk("vec_len", last_len, N);
            chk("vec_ones", last_ones, tbl[i].ones);
            chk("vec_cnt", word_cnt, tbl[i].cnt);
        end

        push(16'h8001);
        push(16'h7FFE);
        wait_idle("b2b");
        chk("b2b_gap", last_gap, 2);
        chk("b2b_len", last_len, N);
        chk("b2b_empty", fifo_empty, 1);
        chk("b2b_cnt", word_cnt, 8);

        en = 1'b0;
        p0 = pops;
        for (int i = 0; i < 8; i++) push(16'hFFFE - 16'(i));
        step(20);
        chk("fill_no_pop", pops - p0, 0);
        chk("fill_idle", busy, 0);
        en = 1'b1;
        wait_idle("drain");
        chk("drain_pops", pops - p0, 8);
        chk("drain_empty", fifo_empty, 1);
        chk("drain_cnt", word_cnt, 16);

        for (int i = 0; i < 3; i++) push(16'($urandom));
        step(1);
        wait_run(10);
        en = 1'b0;
        wait_idle("endrop");
        chk("endrop_len", last_len, N);
        chk("endrop_busy", busy, 0);
        chk("endrop_left", fq.size(), 2);
        chk("endrop_cnt", word_cnt, 17);
        en = 1'b1;
        wait_idle("endrop_drain");
        chk("endrop_drain_cnt", word_cnt, 19);

        push(16'hDEAD);
        push(16'hBEEF);
        step(1);
        wait_run(15);
        reset = 1'b0;
        #1;
        chk("rstmid_outs", {ser_valid, busy, fifo_rd_en}, 0);
        chk("rstmid_cnt", word_cnt, 0);
        step(2);
        reset = 1'b1;
        wait_idle("rstmid");
        chk("rstmid_len", last_len, N);
        chk("rstmid_cnt_after", word_cnt, 1);
        chk("rstmid_empty", fq.size(), 0);

        reset = 1'b0;
        step(2);
        reset = 1'b1;
        step(2);
        for (int i = 0; i < 5; i++) begin
            push(16'($urandom));
            wait_idle("wrap");
            chk("wrap_seq", wc2, wrap_exp[i]);
        end

        sent = 5;
        for (int i = 0; i < 30; i++) begin
            for (int j = $urandom_range(0, 3); j > 0; j--)
                if (fq.size() < 8) push(16'($urandom));
            en = ($urandom % 4) != 0;
            step($urandom_range(1, 40));
        end
        en = 1'b1;
        wait_idle("rand");
        chk("rand_empty", fq.size(), 0);
        chk("rand_cnt", word_cnt, sent % 256);
        chk("rand_cnt_w2", wc2, sent % 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_serializer.md
FIFO_SERIALIZER -- requirements
Module: fifo_serializer

Interface
REQ-001 Parameter DATA_W, default 16, word width; matches the synch_fifo data width.
REQ-002 Parameter BIT_DIV, default 2, clock cycles per serial bit; legal range 1..255.
REQ-003 Parameter CNT_W, default 8, width of word_cnt.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  drain enable; when low, no new FIFO read is started.
REQ-007 fifo_empty  input  1  empty flag of the upstream synch_fifo.
REQ-008 fifo_read_data  input  DATA_W  synch_fifo read port; valid the cycle after fifo_rd_en is high.
REQ-009 fifo_rd_en  output  1  one-cycle pop request to the synch_fifo.
REQ-010 ser_data  output  1  serial bit, MSB first.
REQ-011 ser_valid  output  1  high while ser_data carries a word bit.
REQ-012 ser_first  output  1  high during the bit period of the MSB of each word.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 word_cnt  output  CNT_W  count of fully transmitted words.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, REQ, CAP and SHIFT.
REQ-016 IDLE->REQ SHALL occur when en=1 and fifo_empty=0 are sampled at a rising edge; otherwise the FSM stays in IDLE.
REQ-017 fifo_rd_en SHALL be high exactly during REQ (one cycle) and low in every other state.
REQ-018 REQ->CAP SHALL occur unconditionally; CAP SHALL load fifo_read_data into the shift register at its closing edge; CAP->SHIFT is unconditional.
REQ-019 In SHIFT, ser_valid=1 for exactly DATA_W*BIT_DIV cycles; each bit, MSB first, is held on ser_data for BIT_DIV cycles.
REQ-020 ser_first SHALL be high for the first BIT_DIV cycles of SHIFT only.
REQ-021 In the last SHIFT cycle: if en=1 and fifo_empty=0, go to REQ (back-to-back, 2-cycle ser_valid gap); else go to IDLE.
REQ-022 word_cnt SHALL increment at the closing edge of the last SHIFT cycle and wrap from 2^CNT_W-1 to 0.
REQ-023 Deasserting en mid-word SHALL NOT truncate the word; the current word completes before the FSM returns to IDLE.
REQ-024 fifo_empty SHALL be ignored outside IDLE and the last SHIFT cycle; no pop is issued while the FIFO is empty.
REQ-025 Outside SHIFT: ser_valid=0, ser_first=0, ser_data=0.
REQ-026 Latency: fifo_empty=0 sampled in IDLE at edge E0 -> REQ after E0, CAP after E1, first ser_valid cycle after E2.

Reset
REQ-027 reset=0 SHALL immediately force IDLE and zero all outputs, shift register, bit counter and word_cnt, with no clock required.
REQ-028 Reset during REQ, CAP or SHIFT SHALL discard the in-flight word; no re-read is attempted.
REQ-029 After reset release, the first REQ SHALL occur no earlier than the second rising edge.

Structure
REQ-030 The shared package/include SHALL hold DATA_W and the state encodings (IDLE=2'd0, REQ=2'd1, CAP=2'd2, SHIFT=2'd3).
REQ-031 The bit-period divider SHALL be a sub-module bit_tick_gen: it counts 0..BIT_DIV-1 and emits a one-cycle tick, and is cleared on entry to SHIFT.

Verification (DATA_W=16, BIT_DIV=2, with synch_fifo upstream)
REQ-032 Single word: write 16'hA5C3 -> one fifo_rd_en pulse; ser_data = 1010010111000011, each bit held 2 cycles; ser_valid high 32 cycles; word_cnt=1.
REQ-033 Back-to-back: write 16'h8001 then 16'h7FFE -> two 32-cycle ser_valid bursts separated by exactly 2 low cycles; FIFO empty afterwards; word_cnt=2.
REQ-034 Fill to full (8 words 16'hFFFE..16'hFFF7) with en=0 -> no fifo_rd_en; raise en -> 8 words drained in order; fifo_rd_en never high while empty=1.
REQ-035 en dropped at cycle 10 of SHIFT -> the word completes (32 valid cycles), then IDLE, busy=0; FIFO still holds the remaining words.
REQ-036 reset=0 at cycle 15 of SHIFT -> ser_valid/busy/word_cnt=0 in the same cycle; after release, the next FIFO word is serialized intact.
REQ-037 word_cnt wrap: with CNT_W=2, send 5 words -> word_cnt sequence 1,2,3,0,1.
